// File: rtl/sccb_slave_regfile_if.sv
// Bus and fabric-side signal bundle for the SCCB responder register file.
// The slave modport is the responder's view; master is the bus/fabric side.
`timescale 1ns/1ps
interface sccb_slave_regfile_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, rd_addr,
    output sda_oe, rd_data, wr_strobe, wr_addr, wr_data, busy
  );

  modport master (
    output scl_in, sda_in, rd_addr,
    input  sda_oe, rd_data, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C responder with a 256x8 register file (OV7670-style register model).
// SCL/SDA are oversampled by clock_100Khz; SDA is open-drain via sda_oe.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// DEV       | shifting in device address + R/W
// ACK_DEV   | acknowledging our address
// SUB       | shifting in sub-address
// ACK_SUB   | acknowledging sub-address
// WR        | shifting in a data byte
// ACK_WR    | acknowledging a data byte
// RD        | driving a register byte MSB first
// MACK      | sampling the master's ACK/NACK
// IGNORE    | not addressed / read ended, wait for START or STOP
`timescale 1ns/1ps
module sccb_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter bit         AUTO_INC = 1'b1,
  parameter logic [7:0] PID_VAL  = 8'h76,
  parameter logic [7:0] VER_VAL  = 8'h73
) (
  input logic                  clock_100Khz,
  input logic                  pin_RESET,
  sccb_slave_regfile_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_ACK_DEV, S_SUB, S_ACK_SUB,
    S_WR, S_ACK_WR, S_RD, S_MACK, S_IGNORE
  } state_t;

  localparam logic [7:0] ADDR_PID  = 8'h0A;
  localparam logic [7:0] ADDR_VER  = 8'h0B;
  localparam logic [7:0] ADDR_COM7 = 8'h12;

  function automatic logic [7:0] reg_default(input logic [7:0] idx);
    case (idx)
      ADDR_PID: reg_default = PID_VAL;
      ADDR_VER: reg_default = VER_VAL;
      default:  reg_default = 8'h00;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sub_q, sub_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regs_q [256];
  logic [7:0] regs_d [256];

  logic       scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0] rx_byte, sub_inc;
  logic       reg_we, com7_clr;
  logic [7:0] reg_wa, reg_wd;

  always_comb begin
    scl_s1_d = bus.scl_in;
    scl_s2_d = scl_s1_q;
    scl_h_d  = scl_s2_q;
    sda_s1_d = bus.sda_in;
    sda_s2_d = sda_s1_q;
    sda_h_d  = sda_s2_q;
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign last_bit  = (bit_cnt_q == 4'd7);
  assign rx_byte   = {shift_q[6:0], sda_s2_q};
  assign sub_inc   = AUTO_INC ? sub_q + 8'd1 : sub_q;

  // State register; sync flops reset to the idle-high bus level.
  always_ff @(posedge clock_100Khz or negedge pin_RESET) begin
    if (!pin_RESET) begin
      state_q     <= S_IDLE;
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_h_q     <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_h_q     <= 1'b1;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 4'd0;
      sub_q       <= 8'h00;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < 256; i++) regs_q[i] <= reg_default(8'(i));
    end else begin
      state_q     <= state_d;
      scl_s1_q    <= scl_s1_d;
      scl_s2_q    <= scl_s2_d;
      scl_h_q     <= scl_h_d;
      sda_s1_q    <= sda_s1_d;
      sda_s2_q    <= sda_s2_d;
      sda_h_q     <= sda_h_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      sub_q       <= sub_d;
      rw_q        <= rw_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    if (start_det) begin
      state_d = S_DEV;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_DEV:
          if (scl_rise && last_bit)
            state_d = (rx_byte[7:1] == DEV_ADDR) ? S_ACK_DEV : S_IGNORE;
        S_ACK_DEV: if (scl_fall && phase_q) state_d = rw_q ? S_RD : S_SUB;
        S_SUB:     if (scl_rise && last_bit) state_d = S_ACK_SUB;
        S_ACK_SUB: if (scl_fall && phase_q) state_d = S_WR;
        S_WR:      if (scl_rise && last_bit) state_d = S_ACK_WR;
        S_ACK_WR:  if (scl_fall && phase_q) state_d = S_WR;
        S_RD:      if (scl_fall && bit_cnt_q == 4'd8) state_d = S_MACK;
        S_MACK: begin
          if (scl_rise && sda_s2_q)      state_d = S_IGNORE;
          else if (scl_fall && phase_q)  state_d = S_RD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin : outputs
    sda_oe_d    = sda_oe_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    sub_d       = sub_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    phase_d     = phase_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
    com7_clr    = 1'b0;
    reg_wa      = sub_q;
    reg_wd      = rx_byte;
    if (start_det) begin
      bit_cnt_d = 4'd0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      bit_cnt_d = 4'd0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_SUB, S_WR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              bit_cnt_d = 4'd0;
              phase_d   = 1'b0;
              if (state_q == S_DEV) begin
                busy_d = (rx_byte[7:1] == DEV_ADDR);
                rw_d   = rx_byte[0];
              end else if (state_q == S_SUB) begin
                sub_d = rx_byte;
              end else begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = sub_q;
                wr_data_d   = rx_byte;
                sub_d       = sub_inc;
                // COM7 soft reset wins over storing the byte.
                if (sub_q == ADDR_COM7 && rx_byte[7])
                  com7_clr = 1'b1;
                else if (sub_q != ADDR_PID && sub_q != ADDR_VER)
                  reg_we = 1'b1;
              end
            end
          end
        end
        S_ACK_DEV, S_ACK_SUB, S_ACK_WR: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = 1'b1;
            end else begin
              phase_d   = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == S_ACK_DEV && rw_q) begin
                shift_d  = regs_q[sub_q];
                sda_oe_d = ~regs_q[sub_q][7];
              end
            end
          end
        end
        S_RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              phase_d   = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_MACK: begin
          if (scl_rise) begin
            if (!sda_s2_q) begin
              sub_d   = sub_inc;
              shift_d = regs_q[sub_inc];
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            sda_oe_d  = ~shift_q[7];
            phase_d   = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin : regfile_next
    regs_d = regs_q;
    if (com7_clr) begin
      for (int i = 0; i < 256; i++) regs_d[i] = reg_default(8'(i));
    end else if (reg_we) begin
      regs_d[reg_wa] = reg_wd;
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.busy      = busy_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_data   = regs_q[bus.rd_addr];

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench for sccb_slave_regfile: bit-banged SCCB master on an
// open-drain SDA line, with hand-computed expectations per scenario.
`timescale 1ns/1ps
module tb_sccb_slave_regfile;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic scl = 1'b1;
  logic sda_drv = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   strobe_tot = 0;
  int   oe_tot = 0;

  always #5 clk = ~clk;

  sccb_slave_regfile_if bus ();
  assign bus.scl_in = scl;
  assign bus.sda_in = sda_drv & ~bus.sda_oe;

  sccb_slave_regfile #(
    .DEV_ADDR(7'h21), .AUTO_INC(1'b1), .PID_VAL(8'h76), .VER_VAL(8'h73)
  ) dut (
    .clock_100Khz(clk),
    .pin_RESET(rst_b),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (bus.wr_strobe) strobe_tot++;
    if (bus.sda_oe) oe_tot++;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; wclk(3);
    scl = 1'b1;     wclk(6);
    sda_drv = 1'b0; wclk(6);
    scl = 1'b0;     wclk(3);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; wclk(3);
    scl = 1'b1;     wclk(6);
    sda_drv = 1'b1; wclk(6);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; wclk(3);
    scl = 1'b1;  wclk(6);
    scl = 1'b0;  wclk(3);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; wclk(3);
    scl = 1'b1;     wclk(3);
    ack = ~bus.sda_in;
    wclk(3);
    scl = 1'b0;     wclk(3);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wclk(3); scl = 1'b1;
      wclk(3); d[i] = bus.sda_in;
      wclk(3); scl = 1'b0;
      wclk(3);
    end
    sda_drv = nack; wclk(3);
    scl = 1'b1;     wclk(6);
    scl = 1'b0;     wclk(3);
  endtask

  task automatic test_reset();
    n_chk++; if (bus.sda_oe !== 1'b0) $display("FAIL rst_sda_oe: got %b want 0", bus.sda_oe); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.wr_strobe !== 1'b0) $display("FAIL rst_wr_strobe: got %b want 0", bus.wr_strobe); else n_pass++;
    n_chk++; if (bus.wr_addr !== 8'h00) $display("FAIL rst_wr_addr: got %h want 00", bus.wr_addr); else n_pass++;
    n_chk++; if (bus.wr_data !== 8'h00) $display("FAIL rst_wr_data: got %h want 00", bus.wr_data); else n_pass++;
    bus.rd_addr = 8'h0A; #1;
    n_chk++; if (bus.rd_data !== 8'h76) $display("FAIL rst_reg0A: got %h want 76", bus.rd_data); else n_pass++;
    bus.rd_addr = 8'h0B; #1;
    n_chk++; if (bus.rd_data !== 8'h73) $display("FAIL rst_reg0B: got %h want 73", bus.rd_data); else n_pass++;
    bus.rd_addr = 8'h40; #1;
    n_chk++; if (bus.rd_data !== 8'h00) $display("FAIL rst_reg40: got %h want 00", bus.rd_data); else n_pass++;
  endtask

  task automatic test_single_write();
    logic a0, a1, a2;
    int s0;
    s0 = strobe_tot;
    bus_start();
    write_byte(8'h42, a0);
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL wr_busy_mid: got %b want 1", bus.busy); else n_pass++;
    write_byte(8'h40, a1);
    write_byte(8'hD0, a2);
    bus_stop();
    n_chk++; if ({a0, a1, a2} !== 3'b111) $display("FAIL wr_acks: got %b want 111", {a0, a1, a2}); else n_pass++;
    n_chk++; if (strobe_tot - s0 !== 1) $display("FAIL wr_strobe_cnt: got %0d want 1", strobe_tot - s0); else n_pass++;
    n_chk++; if (bus.wr_addr !== 8'h40) $display("FAIL wr_addr: got %h want 40", bus.wr_addr); else n_pass++;
    n_chk++; if (bus.wr_data !== 8'hD0) $display("FAIL wr_data: got %h want d0", bus.wr_data); else n_pass++;
    bus.rd_addr = 8'h40; #1;
    n_chk++; if (bus.rd_data !== 8'hD0) $display("FAIL wr_reg40: got %h want d0", bus.rd_data); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL wr_busy_stop: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_read_pid();
    logic a0, a1, a2;
    logic [7:0] d;
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h0A, a1);
    bus_stop();
    bus_start();
    write_byte(8'h43, a2);
    read_byte(1'b1, d);
    n_chk++; if ({a0, a1, a2} !== 3'b111) $display("FAIL rd_acks: got %b want 111", {a0, a1, a2}); else n_pass++;
    n_chk++; if (d !== 8'h76) $display("FAIL rd_pid: got %h want 76", d); else n_pass++;
    n_chk++; if (bus.sda_oe !== 1'b0) $display("FAIL rd_oe_nack: got %b want 0", bus.sda_oe); else n_pass++;
    bus_stop();
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rd_busy_stop: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int s0, o0;
    s0 = strobe_tot; o0 = oe_tot;
    bus_start();
    write_byte(8'h60, a0);
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL na_busy_mid: got %b want 0", bus.busy); else n_pass++;
    write_byte(8'h12, a1);
    bus_stop();
    n_chk++; if ({a0, a1} !== 2'b00) $display("FAIL na_acks: got %b want 00", {a0, a1}); else n_pass++;
    n_chk++; if (oe_tot - o0 !== 0) $display("FAIL na_oe_cycles: got %0d want 0", oe_tot - o0); else n_pass++;
    n_chk++; if (strobe_tot - s0 !== 0) $display("FAIL na_strobes: got %0d want 0", strobe_tot - s0); else n_pass++;
  endtask

  task automatic test_autoinc_com7();
    logic a;
    int s0;
    s0 = strobe_tot;
    bus_start();
    write_byte(8'h42, a); write_byte(8'h70, a); write_byte(8'h3A, a); write_byte(8'h35, a);
    bus_stop();
    n_chk++; if (strobe_tot - s0 !== 2) $display("FAIL ai_strobes: got %0d want 2", strobe_tot - s0); else n_pass++;
    bus.rd_addr = 8'h70; #1;
    n_chk++; if (bus.rd_data !== 8'h3A) $display("FAIL ai_reg70: got %h want 3a", bus.rd_data); else n_pass++;
    bus.rd_addr = 8'h71; #1;
    n_chk++; if (bus.rd_data !== 8'h35) $display("FAIL ai_reg71: got %h want 35", bus.rd_data); else n_pass++;
    s0 = strobe_tot;
    bus_start();
    write_byte(8'h42, a); write_byte(8'h0A, a); write_byte(8'h55, a);
    bus_stop();
    n_chk++; if (a !== 1'b1) $display("FAIL ro_ack: got %b want 1", a); else n_pass++;
    n_chk++; if (strobe_tot - s0 !== 1) $display("FAIL ro_strobe: got %0d want 1", strobe_tot - s0); else n_pass++;
    bus.rd_addr = 8'h0A; #1;
    n_chk++; if (bus.rd_data !== 8'h76) $display("FAIL ro_reg0A: got %h want 76", bus.rd_data); else n_pass++;
    bus_start();
    write_byte(8'h42, a); write_byte(8'h12, a); write_byte(8'h80, a);
    bus_stop();
    bus.rd_addr = 8'h70; #1;
    n_chk++; if (bus.rd_data !== 8'h00) $display("FAIL c7_reg70: got %h want 00", bus.rd_data); else n_pass++;
    bus.rd_addr = 8'h71; #1;
    n_chk++; if (bus.rd_data !== 8'h00) $display("FAIL c7_reg71: got %h want 00", bus.rd_data); else n_pass++;
    bus.rd_addr = 8'h0A; #1;
    n_chk++; if (bus.rd_data !== 8'h76) $display("FAIL c7_reg0A: got %h want 76", bus.rd_data); else n_pass++;
    bus.rd_addr = 8'h12; #1;
    n_chk++; if (bus.rd_data !== 8'h00) $display("FAIL c7_reg12: got %h want 00", bus.rd_data); else n_pass++;
  endtask

  task automatic test_wrap_repstart();
    logic a;
    logic [7:0] d0, d1;
    bus_start();
    write_byte(8'h42, a); write_byte(8'hFF, a); write_byte(8'h11, a); write_byte(8'h22, a);
    bus_stop();
    bus.rd_addr = 8'hFF; #1;
    n_chk++; if (bus.rd_data !== 8'h11) $display("FAIL wrap_regFF: got %h want 11", bus.rd_data); else n_pass++;
    bus.rd_addr = 8'h00; #1;
    n_chk++; if (bus.rd_data !== 8'h22) $display("FAIL wrap_reg00: got %h want 22", bus.rd_data); else n_pass++;
    bus_start();
    write_byte(8'h42, a); write_byte(8'hFF, a);
    bus_start();
    write_byte(8'h43, a);
    n_chk++; if (a !== 1'b1) $display("FAIL rs_ack: got %b want 1", a); else n_pass++;
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    bus_stop();
    n_chk++; if (d0 !== 8'h11) $display("FAIL rs_read0: got %h want 11", d0); else n_pass++;
    n_chk++; if (d1 !== 8'h22) $display("FAIL rs_read1_wrap: got %h want 22", d1); else n_pass++;
  endtask

  task automatic test_reset_midxfer();
    logic a;
    int s0;
    bus_start();
    write_byte(8'h42, a);
    for (int i = 7; i >= 0; i--) send_bit(i == 6);
    wclk(2);
    n_chk++; if (bus.sda_oe !== 1'b1) $display("FAIL mr_oe_before: got %b want 1", bus.sda_oe); else n_pass++;
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL mr_busy_before: got %b want 1", bus.busy); else n_pass++;
    #2 rst_b = 1'b0;
    #1;
    n_chk++; if (bus.sda_oe !== 1'b0) $display("FAIL mr_oe_async: got %b want 0", bus.sda_oe); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL mr_busy: got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.wr_data !== 8'h00) $display("FAIL mr_wr_data: got %h want 00", bus.wr_data); else n_pass++;
    bus.rd_addr = 8'hFF; #1;
    n_chk++; if (bus.rd_data !== 8'h00) $display("FAIL mr_regFF: got %h want 00", bus.rd_data); else n_pass++;
    scl = 1'b1; sda_drv = 1'b1;
    wclk(4);
    rst_b = 1'b1;
    wclk(4);
    s0 = strobe_tot;
    bus_start();
    write_byte(8'h42, a); write_byte(8'h40, a); write_byte(8'h55, a);
    bus_stop();
    n_chk++; if (a !== 1'b1) $display("FAIL mr_post_ack: got %b want 1", a); else n_pass++;
    n_chk++; if (strobe_tot - s0 !== 1) $display("FAIL mr_post_strobe: got %0d want 1", strobe_tot - s0); else n_pass++;
    bus.rd_addr = 8'h40; #1;
    n_chk++; if (bus.rd_data !== 8'h55) $display("FAIL mr_post_reg40: got %h want 55", bus.rd_data); else n_pass++;
  endtask

  initial begin
    bus.rd_addr = 8'h00;
    wclk(3);
    rst_b = 1'b1;
    wclk(3);
    test_reset();
    test_single_write();
    test_read_pid();
    test_wrong_addr();
    test_autoinc_com7();
    test_wrap_repstart();
    test_reset_midxfer();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
